gray_rx_checker: RTL and testbench

//  Downstream consumer of the Gray-code counter. Samples gray_in from a foreign or asynchronous

---
 rtl/gray_pkg.sv | 34 +++
 rtl/gray_sync.sv | 36 +++
 rtl/gray_rx_checker.sv | 138 +++++++++++++
 tb/tb_gray_rx_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path.
//   gray2bin : Gray -> binary on a GRAY_MAX_W-wide vector (zero-extend narrower inputs)
//   popcount : number of set bits in a GRAY_MAX_W-wide vector
//   gray_rx_state_t : lock state of the receive checker
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;
  localparam int unsigned POP_W      = 6;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } gray_rx_state_t;

  // Prefix XOR from the MSB down; zero-extended upper bits leave the low result intact.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [GRAY_MAX_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into the clk domain.
// Ports:
//   clk    : destination clock
//   resetn : asynchronous active-low reset, clears every stage
//   d      : unsynchronised input bus
//   q      : output of the last synchroniser stage
// The stages form a plain shift chain; nothing sits between flops.
module gray_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift chain of synchroniser flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_rx_checker.sv
// Receive-side checker for a Gray-coded counter crossing a clock boundary.
// Synchronises gray_in, converts it to binary, flags each new value as a legal
// +1 step or an error, and tracks lock to the incoming sequence.
// Ports:
//   clk       : clock
//   resetn    : asynchronous active-low reset
//   gray_in   : Gray count from upstream (unsynchronised)
//   bin_out   : binary value of the synchronised Gray input, updated on change
//   bin_valid : one-cycle pulse when bin_out updates
//   step_err  : one-cycle pulse on an illegal step while locked
//   locked    : high while the checker is locked to the sequence
//   err_count : saturating count of step_err pulses
// Build option: define GRAY_RX_BIDIR_EN to also accept -1 steps (up/down source).
module gray_rx_checker
  import gray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CNT    = 3,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] gray_in,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  bin_valid,
  output logic                  step_err,
  output logic                  locked,
  output logic [ERR_W-1:0]      err_count
);

  // step_cnt only needs to hold 0..LOCK_CNT-1.
  localparam int unsigned CNT_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  logic [DATA_WIDTH-1:0] g_s;
  logic [DATA_WIDTH-1:0] g_prev;
  logic [DATA_WIDTH-1:0] b_c;
  logic                  change_c;
  logic                  one_bit_c;
  logic                  step_up_c;
  logic                  step_dn_c;
  logic                  legal_c;

  gray_rx_state_t        state;
  gray_rx_state_t        state_nxt;
  logic [CNT_W-1:0]      step_cnt;
  logic [CNT_W-1:0]      step_cnt_nxt;
  logic [ERR_W-1:0]      err_count_nxt;
  logic                  step_err_nxt;

  gray_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (gray_in),
    .q      (g_s)
  );

  // Conversion and step classification against the last accepted value.
  assign b_c       = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(g_s)));
  assign change_c  = (g_s != g_prev);
  assign one_bit_c = (popcount(GRAY_MAX_W'(g_s ^ g_prev)) == POP_W'(1));
  assign step_up_c = (b_c == bin_out + DATA_WIDTH'(1));

`ifdef GRAY_RX_BIDIR_EN
  assign step_dn_c = (b_c == bin_out - DATA_WIDTH'(1));
`else
  assign step_dn_c = 1'b0;
`endif

  assign legal_c = one_bit_c && (step_up_c || step_dn_c);

  // Lock FSM next state; only a change in the synchronised value is an event.
  always_comb begin
    state_nxt     = state;
    step_cnt_nxt  = step_cnt;
    err_count_nxt = err_count;
    step_err_nxt  = 1'b0;
    if (change_c) begin
      case (state)
        UNLOCKED: begin
          if (legal_c) begin
            if (step_cnt == CNT_W'(LOCK_CNT - 1)) begin
              state_nxt    = LOCKED;
              step_cnt_nxt = '0;
            end else begin
              step_cnt_nxt = step_cnt + CNT_W'(1);
            end
          end else begin
            step_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (!legal_c) begin
            step_err_nxt = 1'b1;
            state_nxt    = UNLOCKED;
            step_cnt_nxt = '0;
            if (err_count != {ERR_W{1'b1}}) begin
              err_count_nxt = err_count + ERR_W'(1);
            end
          end
        end
        default: begin
          state_nxt    = UNLOCKED;
          step_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State, history and registered outputs; all update together on a change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= UNLOCKED;
      step_cnt  <= '0;
      g_prev    <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      step_cnt  <= step_cnt_nxt;
      bin_valid <= change_c;
      step_err  <= step_err_nxt;
      locked    <= (state_nxt == LOCKED);
      err_count <= err_count_nxt;
      if (change_c) begin
        g_prev  <= g_s;
        bin_out <= b_c;
      end
    end
  end

endmodule

// File: tb/tb_gray_rx_checker.sv
// Randomised self-checking bench for gray_rx_checker (4-bit, 2 sync stages, lock after 3).
module tb_gray_rx_checker;

  localparam int unsigned DW = 4;
  localparam int unsigned EW = 8;
  localparam int          N  = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] gray_in;
  logic [DW-1:0] bin_out;
  logic          bin_valid;
  logic          step_err;
  logic          locked;
  logic [EW-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: last accepted value, lock progress, error tally.
  int m_gray   = 0;
  int m_bin    = 0;
  int m_cnt    = 0;
  int m_err    = 0;
  bit m_locked = 1'b0;
  bit m_bidir  = 1'b0;

  gray_rx_checker #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2),
    .LOCK_CNT    (3),
    .ERR_W       (EW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .step_err  (step_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_gray(input int i);
    return (i ^ (i >> 1)) & (N - 1);
  endfunction

  // Decode by searching the Gray sequence for the position of g.
  function automatic int seq_pos(input int g);
    for (int i = 0; i < N; i++) begin
      if (to_gray(i) == g) return i;
    end
    return -1;
  endfunction

  // Drive one value, hold it, and check the outputs against the model.
  task automatic apply(input int g, input int extra);
    bit chg;
    bit exp_err;
    bit legal;
    int b;
    int old_bin;
    chg     = (g != m_gray);
    exp_err = 1'b0;
    old_bin = m_bin;
    if (chg) begin
      b     = seq_pos(g);
      legal = (b == (m_bin + 1) % N) || (m_bidir && b == (m_bin + N - 1) % N);
      if (m_locked) begin
        if (!legal) begin
          exp_err  = 1'b1;
          m_locked = 1'b0;
          m_cnt    = 0;
          if (m_err < 255) m_err++;
        end
      end else if (legal) begin
        m_cnt++;
        if (m_cnt == 3) begin
          m_locked = 1'b1;
          m_cnt    = 0;
        end
      end else begin
        m_cnt = 0;
      end
      m_gray = g;
      m_bin  = b;
    end
    gray_in = DW'(g);
    repeat (2) @(posedge clk);
    #1;
    check_eq("bin_out_latency", 32'(bin_out), 32'(old_bin));
    @(posedge clk);
    #1;
    check_eq("bin_valid", 32'(bin_valid), 32'(chg));
    check_eq("bin_out", 32'(bin_out), 32'(m_bin));
    check_eq("step_err", 32'(step_err), 32'(exp_err));
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("err_count", 32'(err_count), 32'(m_err));
    @(posedge clk);
    #1;
    check_eq("bin_valid_pulse", 32'(bin_valid), 32'(0));
    check_eq("step_err_pulse", 32'(step_err), 32'(0));
    repeat (extra) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_up();
    apply(to_gray((m_bin + 1) % N), $urandom_range(0, 2));
  endtask

  task automatic step_down();
    apply(to_gray((m_bin + N - 1) % N), $urandom_range(0, 2));
  endtask

  task automatic step_illegal();
    int idx;
    idx = $urandom_range(0, N - 1);
    while (idx == m_bin || idx == (m_bin + 1) % N ||
           (m_bidir && idx == (m_bin + N - 1) % N)) begin
      idx = $urandom_range(0, N - 1);
    end
    apply(to_gray(idx), $urandom_range(0, 1));
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_bin_out", 32'(bin_out), 32'(0));
    check_eq("rst_bin_valid", 32'(bin_valid), 32'(0));
    check_eq("rst_step_err", 32'(step_err), 32'(0));
    check_eq("rst_locked", 32'(locked), 32'(0));
    check_eq("rst_err_count", 32'(err_count), 32'(0));
    gray_in = '0;
    m_gray   = 0;
    m_bin    = 0;
    m_cnt    = 0;
    m_err    = 0;
    m_locked = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq8 [8];
    int r;
`ifdef GRAY_RX_BIDIR_EN
    m_bidir = 1'b1;
`endif
    seq8 = '{0, 1, 3, 2, 6, 7, 5, 4};
    resetn  = 1'b0;
    gray_in = '0;
    @(posedge clk);
    #1;
    check_eq("init_bin_out", 32'(bin_out), 32'(0));
    check_eq("init_locked", 32'(locked), 32'(0));
    check_eq("init_err_count", 32'(err_count), 32'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic count sequence 0..7, lock after the third step.
    foreach (seq8[i]) apply(seq8[i], 0);

    // Two full laps while locked, including the 1000 -> 0000 wrap.
    repeat (2 * N) step_up();

    // Two-bit jump 0110 -> 0101 while locked, then relock.
    while (m_bin != 4) step_up();
    apply(5, 0);
    repeat (3) step_up();

    // Many illegal steps with relock in between; err_count saturates.
    repeat (300) begin
      step_illegal();
      repeat (3) step_up();
    end
    check_eq("err_saturated", 32'(err_count), 32'(255));

    // Down step 0111 -> 0110: legal only in the bidirectional build.
    while (m_bin != 5) step_up();
    apply(6, 0);

    // Mid-run asynchronous reset from a locked state.
    repeat (4) step_up();
    async_reset();

    // Randomised mix of up, down, hold and arbitrary jumps.
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r <= 5) step_up();
      else if (r == 6) step_down();
      else if (r == 7) apply(m_gray, 0);
      else apply($urandom_range(0, N - 1), $urandom_range(0, 1));
    end

    repeat (3) step_up();
    async_reset();
    apply(1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
